// File: rtl/bitstream_fetch.sv
// Byte-granular bitstream fetch buffer between a 32-bit word source
// and a byte-popping entropy decoder, with slice start/end tracking.
module bitstream_fetch #(
    parameter int DEPTH_WORDS = 4,
    parameter int PRIME_BYTES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_word,
    input  logic        s_last,
    input  logic        request_byte,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        stall,
    output logic        eos,
    output logic        underflow,
    output logic [4:0]  level
);

    localparam int CAP = 4 * DEPTH_WORDS;
    localparam int PW  = $clog2(CAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    mem [CAP];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          last_seen;
    logic          push;
    logic          pop;
    logic          uf_set;
    logic          start_go;
    logic          active;

    assign active   = (state == FILL) || (state == RUN);
    assign push     = s_valid && s_ready && !flush;
    assign pop      = request_byte && (state == RUN)
                      && (level != 5'd0) && !flush;
    assign uf_set   = request_byte && (level == 5'd0)
                      && ((state == RUN) || (state == DONE));
    assign start_go = start && !flush
                      && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nx = FILL;
                FILL: if (level >= 5'(PRIME_BYTES) || last_seen)
                          state_nx = RUN;
                RUN:  if (last_seen && level == 5'd0)
                          state_nx = DONE;
                DONE: if (start) state_nx = FILL;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs derived from state and registered occupancy
    always_comb begin
        s_ready    = active && (level <= 5'(CAP - 4)) && !last_seen;
        data       = (level != 5'd0) ? mem[rptr] : 8'h00;
        data_valid = (level != 5'd0);
        eos        = (state == DONE);
        stall      = (state == FILL)
                     || ((state == RUN) && (level == 5'd0) && !last_seen);
    end

    // Pointers, occupancy and slice flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            last_seen <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            last_seen <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(4);
            if (pop)  rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + 5'd4;
                2'b01:   level <= level - 5'd1;
                2'b11:   level <= level + 5'd3;
                default: level <= level;
            endcase
            if (start_go)          last_seen <= 1'b0;
            else if (push && s_last) last_seen <= 1'b1;
            if (start_go)    underflow <= 1'b0;
            else if (uf_set) underflow <= 1'b1;
        end
    end

    // Byte storage; MSB byte of the word lands first in stream order
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                mem[wptr + PW'(k)] <= s_word[31-8*k -: 8];
            end
        end
    end

endmodule

// File: tb/tb_bitstream_fetch.sv
// Directed self-checking bench for bitstream_fetch.
// Expected values are hand-derived from the stream contents.
module tb_bitstream_fetch;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_word;
    logic        s_last;
    logic        request_byte;
    logic [7:0]  data;
    logic        data_valid;
    logic        stall;
    logic        eos;
    logic        underflow;
    logic [4:0]  level;

    int n_vec;
    int n_bad;

    bitstream_fetch #(.DEPTH_WORDS(4), .PRIME_BYTES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_word       (s_word),
        .s_last       (s_last),
        .request_byte (request_byte),
        .data         (data),
        .data_valid   (data_valid),
        .stall        (stall),
        .eos          (eos),
        .underflow    (underflow),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input logic l);
        s_valid = 1'b1;
        s_word  = w;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, data}, {24'h0, exp});
        request_byte = 1'b1;
        tick();
        request_byte = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        s_valid = 1'b0;
        s_word = '0;
        s_last = 1'b0;
        request_byte = 1'b0;
        #12;
        chk("rst_s_ready", {31'h0, s_ready}, 32'd0);
        chk("rst_data", {24'h0, data}, 32'h00);
        chk("rst_dvalid", {31'h0, data_valid}, 32'd0);
        chk("rst_stall", {31'h0, stall}, 32'd0);
        chk("rst_eos", {31'h0, eos}, 32'd0);
        chk("rst_uflow", {31'h0, underflow}, 32'd0);
        chk("rst_level", {27'h0, level}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Prime
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fill_stall", {31'h0, stall}, 32'd1);
        chk("fill_ready", {31'h0, s_ready}, 32'd1);
        push_word(32'hA1B2C3D4, 1'b0);
        chk("prime_level_fill", {27'h0, level}, 32'd4);
        tick();
        chk("prime_stall", {31'h0, stall}, 32'd0);
        chk("prime_level", {27'h0, level}, 32'd4);
        chk("prime_data", {24'h0, data}, 32'hA1);
        chk("prime_dvalid", {31'h0, data_valid}, 32'd1);

        // Ordered pop
        pop_byte("pop0", 8'hA1);
        pop_byte("pop1", 8'hB2);
        pop_byte("pop2", 8'hC3);
        pop_byte("pop3", 8'hD4);
        chk("empty_data", {24'h0, data}, 32'h00);
        chk("empty_level", {27'h0, level}, 32'd0);
        chk("empty_stall", {31'h0, stall}, 32'd1);
        chk("empty_dvalid", {31'h0, data_valid}, 32'd0);

        // Full and wrap
        for (int i = 0; i < 4; i++) begin
            chk("full_ready_pre", {31'h0, s_ready}, 32'd1);
            push_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 1'b0);
        end
        chk("full_level", {27'h0, level}, 32'd16);
        chk("full_ready", {31'h0, s_ready}, 32'd0);
        s_valid = 1'b1;
        s_word  = 32'h10111213;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", {24'h0, data}, 32'(i));
            request_byte = 1'b1;
            tick();
            chk("drain_level", {27'h0, level}, 32'(15 - i));
        end
        request_byte = 1'b0;
        chk("reopen_ready", {31'h0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        chk("refill_level", {27'h0, level}, 32'd16);
        for (int i = 4; i < 20; i++) begin
            b = 8'(i);
            pop_byte("wrap_data", b);
        end
        chk("wrap_level", {27'h0, level}, 32'd0);

        // End of slice
        push_word(32'h11223344, 1'b1);
        chk("last_ready", {31'h0, s_ready}, 32'd0);
        pop_byte("eos_b0", 8'h11);
        pop_byte("eos_b1", 8'h22);
        pop_byte("eos_b2", 8'h33);
        pop_byte("eos_b3", 8'h44);
        chk("tail_stall", {31'h0, stall}, 32'd0);
        chk("tail_eos", {31'h0, eos}, 32'd0);
        tick();
        chk("done_eos", {31'h0, eos}, 32'd1);
        chk("done_ready", {31'h0, s_ready}, 32'd0);
        request_byte = 1'b1;
        tick();
        request_byte = 1'b0;
        chk("uflow_set", {31'h0, underflow}, 32'd1);
        chk("uflow_data", {24'h0, data}, 32'h00);

        // Restart, simultaneous push/pop, start+flush
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_uflow", {31'h0, underflow}, 32'd0);
        chk("restart_eos", {31'h0, eos}, 32'd0);
        request_byte = 1'b1;
        tick();
        request_byte = 1'b0;
        chk("fill_req_ignored", {31'h0, underflow}, 32'd0);
        push_word(32'hAABBCCDD, 1'b0);
        push_word(32'hEEFF0011, 1'b0);
        chk("sim_level8", {27'h0, level}, 32'd8);
        pop_byte("sim_b0", 8'hAA);
        pop_byte("sim_b1", 8'hBB);
        pop_byte("sim_b2", 8'hCC);
        chk("sim_level5", {27'h0, level}, 32'd5);
        chk("sim_data", {24'h0, data}, 32'hDD);
        s_valid = 1'b1;
        s_word  = 32'h22334455;
        request_byte = 1'b1;
        tick();
        s_valid = 1'b0;
        request_byte = 1'b0;
        chk("pushpop_level", {27'h0, level}, 32'd8);
        chk("pushpop_data", {24'h0, data}, 32'hEE);
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_level", {27'h0, level}, 32'd0);
        chk("flush_stall", {31'h0, stall}, 32'd0);
        chk("flush_ready", {31'h0, s_ready}, 32'd0);
        chk("flush_eos", {31'h0, eos}, 32'd0);

        // Reset mid-operation
        start = 1'b1;
        tick();
        start = 1'b0;
        push_word(32'h01020304, 1'b0);
        push_word(32'h05060708, 1'b0);
        pop_byte("mid_b0", 8'h01);
        chk("mid_level", {27'h0, level}, 32'd7);
        chk("mid_stall", {31'h0, stall}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_level", {27'h0, level}, 32'd0);
        chk("arst_data", {24'h0, data}, 32'h00);
        chk("arst_dvalid", {31'h0, data_valid}, 32'd0);
        chk("arst_ready", {31'h0, s_ready}, 32'd0);
        chk("arst_stall", {31'h0, stall}, 32'd0);
        chk("arst_eos", {31'h0, eos}, 32'd0);
        chk("arst_uflow", {31'h0, underflow}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bitstream_fetch.md
BITSTREAM_FETCH -- requirements
Module: bitstream_fetch

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4, meaning 32-bit words of byte buffer (capacity CAP = 4*DEPTH_WORDS bytes = 16).
REQ-002 SHALL have parameter PRIME_BYTES, default 2, meaning bytes buffered before leaving FILL.
REQ-003 clk  in  1  rising-edge clock, single clock domain.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  begin slice; IDLE/DONE -> FILL.
REQ-006 flush  in  1  abort; clear buffer and flags, go IDLE.
REQ-007 s_valid / s_ready  in / out  1 / 1  upstream word handshake.
REQ-008 s_word  in  32  bitstream word; byte [31:24] consumed first.
REQ-009 s_last  in  1  qualifies the final word of the slice.
REQ-010 request_byte  in  1  decoder pop strobe.
REQ-011 data  out  8  head byte to decoder.
REQ-012 data_valid  out  1  buffer non-empty.
REQ-013 stall  out  1  decoder must hold.
REQ-014 eos  out  1  slice fully consumed.
REQ-015 underflow  out  1  sticky: pop attempted on empty buffer.
REQ-016 level  out  5  bytes held, 0..CAP.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, RUN, DONE.
REQ-018 Transitions: IDLE -start-> FILL; FILL -> RUN when level >= PRIME_BYTES or last_seen; RUN -> DONE when last_seen and level==0; DONE -start-> FILL; any state -flush-> IDLE.
REQ-019 flush SHALL take priority over start and over any push/pop in the same cycle.
REQ-020 s_ready SHALL be 1 only in FILL or RUN with CAP - level >= 4 and last_seen==0, computed from registered level (same-cycle pop ignored).
REQ-021 Push (s_valid && s_ready) SHALL write 4 bytes in order [31:24],[23:16],[15:8],[7:0] at the circular write pointer; level += 4.
REQ-022 Push with s_last=1 SHALL set last_seen; last_seen clears on flush or start.
REQ-023 Pop SHALL occur when request_byte==1, state==RUN, level>0; read pointer advances by 1, wrapping modulo CAP.
REQ-024 Simultaneous push and pop SHALL give level += 3.
REQ-025 request_byte in IDLE or FILL SHALL be ignored (no pop, no underflow).
REQ-026 request_byte in RUN or DONE with level==0 SHALL set underflow; no pointer change; cleared only by flush, start, or reset.
REQ-027 data SHALL equal the byte at the read pointer when level>0, else 8'h00 (zero padding), combinationally, so the decoder samples it in the same cycle it asserts request_byte.
REQ-028 data_valid SHALL equal (level != 0).
REQ-029 stall SHALL be 1 in FILL, and in RUN when level==0 and last_seen==0; 0 otherwise.
REQ-030 eos SHALL be 1 exactly in DONE.
REQ-031 Pointers SHALL be log2(CAP) bits and wrap naturally; level SHALL never exceed CAP nor go below 0.
REQ-032 Push-to-data latency SHALL be 1 cycle: a byte written at edge N is visible on data after edge N when it is the head.

Reset
REQ-033 reset_n low SHALL asynchronously force state IDLE, pointers 0, level 0, last_seen 0, underflow 0.
REQ-034 During reset: s_ready=0, data=8'h00, data_valid=0, stall=0, eos=0, underflow=0, level=0.
REQ-035 Release SHALL be synchronous to clk; first active edge after deassertion evaluates normally.

Verification
REQ-036 Prime: start, push 0xA1B2C3D4 with s_last=0 -> next cycle state RUN, level=4, data=0xA1, stall=0.
REQ-037 Ordered pop: after REQ-036, request_byte 4 cycles -> data sequence 0xA1,0xB2,0xC3,0xD4 then 0x00, level 0, stall=1.
REQ-038 Full/wrap: push 4 words (level=16), s_ready=0; pop 4 bytes with push each cycle of the 5th word -> level 16->15->14->13->12 then s_ready=1 on a single push leaving level 16; bytes continue in order across pointer wrap.
REQ-039 End of slice: push 0x11223344 with s_last=1, pop 4 -> eos=1 next cycle, s_ready=0; 5th pop -> underflow=1, data=0x00.
REQ-040 Simultaneous: push and pop same cycle at level=5 -> level=8; start and flush same cycle -> state IDLE.
REQ-041 Reset mid-operation: reset_n low at level=7 in RUN -> outputs immediately take REQ-034 values without a clock edge.
